// File: rtl/vai_master_if.sv
// rtl/vai_master_if.sv - controller request/response and VAI stream signals of vai_master
interface vai_master_if;
    logic       ReqValid_i;
    logic       ReqWrite_i;
    logic [3:0] ReqAddr_i;
    logic [7:0] ReqData_i;
    logic       ReqAccept_o;
    logic       RespValid_o;
    logic [7:0] RespData_o;
    logic       RespError_o;
    logic       RespTimeout_o;
    logic       RespAccept_i;
    logic [7:0] Dout_o;
    logic       DoutValid_o;
    logic       DoutStart_o;
    logic       DoutStop_o;
    logic       DoutAccept_i;
    logic [7:0] Din_i;
    logic       DinValid_i;
    logic       DinStart_i;
    logic       DinStop_i;
    logic       DinAccept_o;

    modport master (
        input  ReqValid_i, ReqWrite_i, ReqAddr_i, ReqData_i, RespAccept_i,
               DoutAccept_i, Din_i, DinValid_i, DinStart_i, DinStop_i,
        output ReqAccept_o, RespValid_o, RespData_o, RespError_o, RespTimeout_o,
               Dout_o, DoutValid_o, DoutStart_o, DoutStop_o, DinAccept_o
    );

    modport slave (
        output ReqValid_i, ReqWrite_i, ReqAddr_i, ReqData_i, RespAccept_i,
               DoutAccept_i, Din_i, DinValid_i, DinStart_i, DinStop_i,
        input  ReqAccept_o, RespValid_o, RespData_o, RespError_o, RespTimeout_o,
               Dout_o, DoutValid_o, DoutStart_o, DoutStop_o, DinAccept_o
    );
endinterface

// File: rtl/vai_master.sv
// rtl/vai_master.sv - single-outstanding VAI request master with response collection and timeout
module vai_master #(
    parameter int TIMEOUT = 255
) (
    input  logic         Clk_i,
    input  logic         Reset_n_i,
    vai_master_if.master vai
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_HEADER, S_SEND_DATA, S_GET_HEADER, S_GET_DATA, S_GET_FOOTER, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_addr;
    logic            r_write;
    logic [7:0]      r_wdata;
    logic [7:0]      r_rdata;
    logic            r_slv_err;
    logic            r_frm_err;
    logic            r_tmo;
    logic [CW-1:0]   r_cnt;

    logic [7:0]      w_hdr;
    logic            w_in_get;
    logic            w_tmo_hit;
    logic            w_err;

    assign w_hdr     = {r_addr, 3'b000, r_write};
    assign w_in_get  = (r_state == S_GET_HEADER) || (r_state == S_GET_DATA) || (r_state == S_GET_FOOTER);
    // Counts consecutive waiting cycles; an arriving beat wins over an expiring count.
    assign w_tmo_hit = (TIMEOUT > 0) && w_in_get && !vai.DinValid_i && (r_cnt == CNT_LAST);
    assign w_err     = r_slv_err | r_frm_err | r_tmo;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (vai.ReqValid_i) w_next = S_SEND_HEADER;
            S_SEND_HEADER: if (vai.DoutAccept_i) w_next = r_write ? S_SEND_DATA : S_GET_HEADER;
            S_SEND_DATA:   if (vai.DoutAccept_i) w_next = S_GET_HEADER;
            S_GET_HEADER: begin
                if (vai.DinValid_i) begin
                    if (vai.DinStart_i) w_next = r_write ? S_GET_FOOTER : S_GET_DATA;
                end else if (w_tmo_hit) w_next = S_DONE;
            end
            S_GET_DATA: begin
                if (vai.DinValid_i) begin
                    if (vai.DinStop_i)        w_next = S_DONE;
                    else if (!vai.DinStart_i) w_next = S_GET_FOOTER;
                end else if (w_tmo_hit) w_next = S_DONE;
            end
            S_GET_FOOTER: begin
                if (vai.DinValid_i) begin
                    if (vai.DinStop_i) w_next = S_DONE;
                end else if (w_tmo_hit) w_next = S_DONE;
            end
            S_DONE:        if (vai.RespAccept_i) w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_slv_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_tmo     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if ((TIMEOUT > 0) && w_in_get && !vai.DinValid_i) r_cnt <= r_cnt + CW'(1);
            else                                             r_cnt <= '0;
            if (w_tmo_hit) r_tmo <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (vai.ReqValid_i) begin
                        r_addr    <= vai.ReqAddr_i;
                        r_write   <= vai.ReqWrite_i;
                        r_wdata   <= vai.ReqData_i;
                        r_rdata   <= '0;
                        r_slv_err <= 1'b0;
                        r_frm_err <= 1'b0;
                        r_tmo     <= 1'b0;
                    end
                end
                S_GET_HEADER: begin
                    if (vai.DinValid_i && (!vai.DinStart_i || (vai.Din_i != w_hdr))) r_frm_err <= 1'b1;
                end
                S_GET_DATA: begin
                    if (vai.DinValid_i) begin
                        // A premature Stop still carries the slave's footer status.
                        if (vai.DinStop_i) begin
                            r_frm_err <= 1'b1;
                            r_slv_err <= vai.Din_i[0];
                        end else if (!vai.DinStart_i) r_rdata <= vai.Din_i;
                        else                          r_frm_err <= 1'b1;
                    end
                end
                S_GET_FOOTER: begin
                    if (vai.DinValid_i) begin
                        if (vai.DinStop_i) r_slv_err <= vai.Din_i[0];
                        else               r_frm_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vai.ReqAccept_o   = (r_state == S_IDLE);
    assign vai.DoutValid_o   = (r_state == S_SEND_HEADER) || (r_state == S_SEND_DATA);
    assign vai.DoutStart_o   = (r_state == S_SEND_HEADER);
    assign vai.DoutStop_o    = ((r_state == S_SEND_HEADER) && !r_write) || (r_state == S_SEND_DATA);
    assign vai.Dout_o        = (r_state == S_SEND_HEADER) ? w_hdr :
                               (r_state == S_SEND_DATA)   ? r_wdata : 8'h00;
    assign vai.DinAccept_o   = w_in_get;
    assign vai.RespValid_o   = (r_state == S_DONE);
    assign vai.RespError_o   = (r_state == S_DONE) && w_err;
    assign vai.RespTimeout_o = (r_state == S_DONE) && r_tmo;
    assign vai.RespData_o    = ((r_state == S_DONE) && !r_write && !w_err) ? r_rdata : 8'h00;
endmodule
